// File: rtl/spi_slave_ram_ctrl_if.sv
// RAM-side access port of the SPI slave controller (256 x 16 RAM).
interface spi_slave_ram_ctrl_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport master (
    output ram_we, ram_re, ram_write_addr, ram_read_addr, ram_data_in,
    input  ram_data_out
  );

  modport slave (
    input  ram_we, ram_re, ram_write_addr, ram_read_addr, ram_data_in,
    output ram_data_out
  );
endinterface

// File: rtl/spi_slave_ram_ctrl.sv
// SPI mode-0 slave that turns 32-bit frames (cmd, addr, data) into RAM accesses.
module spi_slave_ram_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sclk,
  input  logic                        cs_n,
  input  logic                        mosi,
  output logic                        miso,
  output logic                        miso_oe,
  output logic                        frame_done,
  output logic                        frame_err,
  spi_slave_ram_ctrl_if.master        ram
);
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 6;
  localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_RD0  = CNT_W'(17);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(32);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_FETCH, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, sync_vld;
  logic sclk_d, cs_d, armed;
  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] rx_sr, rx_nxt, tx_sr, tx_nxt;
  logic              cmd_wr, cmd_wr_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              miso_nxt, miso_oe_nxt, frame_done_nxt, frame_err_nxt;
  logic              ram_we_q, ram_we_nxt, ram_re_q, ram_re_nxt;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt, rd_addr_q, rd_addr_nxt;
  logic [DATA_W-1:0] wr_data_q, wr_data_nxt;

  // Oversample async SPI pins; sync_vld marks when the chain holds real pin samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sync_vld  <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      // a frame may only start once cs_n has really been seen high after reset
      if (sync_vld[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign ram.ram_we         = ram_we_q;
  assign ram.ram_re         = ram_re_q;
  assign ram.ram_write_addr = wr_addr_q;
  assign ram.ram_read_addr  = rd_addr_q;
  assign ram.ram_data_in    = wr_data_q;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      cmd_wr     <= 1'b0;
      addr_q     <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_data_q  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      rx_sr      <= rx_nxt;
      tx_sr      <= tx_nxt;
      cmd_wr     <= cmd_wr_nxt;
      addr_q     <= addr_nxt;
      miso       <= miso_nxt;
      miso_oe    <= miso_oe_nxt;
      ram_we_q   <= ram_we_nxt;
      ram_re_q   <= ram_re_nxt;
      wr_addr_q  <= wr_addr_nxt;
      rd_addr_q  <= rd_addr_nxt;
      wr_data_q  <= wr_data_nxt;
      frame_done <= frame_done_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  // Frame decode: next state, bit shifting and strobe generation
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    rx_nxt         = rx_sr;
    tx_nxt         = tx_sr;
    cmd_wr_nxt     = cmd_wr;
    addr_nxt       = addr_q;
    miso_nxt       = miso;
    miso_oe_nxt    = miso_oe;
    ram_we_nxt     = 1'b0;
    ram_re_nxt     = 1'b0;
    wr_addr_nxt    = wr_addr_q;
    rd_addr_nxt    = rd_addr_q;
    wr_data_nxt    = wr_data_q;
    frame_done_nxt = 1'b0;
    frame_err_nxt  = 1'b0;

    if ((state inside {CMD, ADDR, RD_FETCH, DATA}) && sclk_rise) begin
      rx_nxt = {rx_sr[DATA_W-2:0], mosi_s};
      if (bit_cnt != CNT_END) bit_cnt_nxt = bit_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (armed && cs_fall) begin
          state_nxt   = CMD;
          bit_cnt_nxt = '0;
        end
      end
      CMD: begin
        if (bit_cnt == CNT_CMD) begin
          cmd_wr_nxt = rx_sr[7];
          state_nxt  = ADDR;
        end
      end
      ADDR: begin
        // read: issue ram_re, then move on in the cycle it is visible so RD_FETCH sees the data
        if (bit_cnt == CNT_ADDR) begin
          addr_nxt = rx_sr[ADDR_W-1:0];
          if (cmd_wr) begin
            state_nxt = DATA;
          end else if (ram_re_q) begin
            state_nxt = RD_FETCH;
          end else begin
            ram_re_nxt  = 1'b1;
            rd_addr_nxt = rx_sr[ADDR_W-1:0];
          end
        end
      end
      RD_FETCH: begin
        tx_nxt      = ram.ram_data_out;
        miso_nxt    = ram.ram_data_out[DATA_W-1];
        miso_oe_nxt = 1'b1;
        state_nxt   = DATA;
      end
      DATA: begin
        if (bit_cnt == CNT_END) begin
          state_nxt      = DONE;
          frame_done_nxt = 1'b1;
          if (cmd_wr) begin
            ram_we_nxt  = 1'b1;
            wr_addr_nxt = addr_q;
            wr_data_nxt = rx_sr;
          end
        end else if (!cmd_wr && sclk_fall && bit_cnt >= CNT_RD0) begin
          tx_nxt   = {tx_sr[DATA_W-2:0], 1'b0};
          miso_nxt = tx_sr[DATA_W-2];
        end
      end
      DONE: ;
      default: state_nxt = IDLE;
    endcase

    // cs_n high ends the frame from any state; anything decoded this cycle is dropped
    if (state != IDLE && cs_s) begin
      state_nxt      = IDLE;
      miso_nxt       = 1'b0;
      miso_oe_nxt    = 1'b0;
      ram_we_nxt     = 1'b0;
      ram_re_nxt     = 1'b0;
      wr_addr_nxt    = wr_addr_q;
      rd_addr_nxt    = rd_addr_q;
      wr_data_nxt    = wr_data_q;
      frame_done_nxt = 1'b0;
      frame_err_nxt  = (bit_cnt != '0) && (bit_cnt != CNT_END);
    end
  end
endmodule

// File: tb/tb_spi_slave_ram_ctrl.sv
// Bench for spi_slave_ram_ctrl: SPI master driver, RAM model and write/read scoreboards.
module tb_spi_slave_ram_ctrl;
  localparam int unsigned HALF = 4;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
    logic        done;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n, sclk, cs_n, mosi, miso, miso_oe, frame_done, frame_err;

  spi_slave_ram_ctrl_if ram ();

  spi_slave_ram_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .frame_done(frame_done),
    .frame_err(frame_err), .ram(ram)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  int oe_bad = 0;
  logic [15:0] rd_word;
  wr_t wr_obs[$];
  wr_t wr_exp[$];
  logic [7:0] re_obs[$];
  logic [7:0] re_exp[$];
  logic [15:0] mem [256];

  // 1-cycle latency RAM model
  always @(posedge clk) begin
    if (ram.ram_re) ram.ram_data_out <= mem[ram.ram_read_addr];
    if (ram.ram_we) mem[ram.ram_write_addr] <= ram.ram_data_in;
  end

  // Observe strobes between clock edges
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram.ram_we) wr_obs.push_back(wr_t'{ram.ram_write_addr, ram.ram_data_in, frame_done});
      if (ram.ram_re) re_obs.push_back(ram.ram_read_addr);
      if (frame_done) n_done++;
      if (frame_err) n_err++;
      if (ram.ram_we && ram.ram_re) n_both++;
    end
  end

  task automatic spi_start();
    @(negedge clk);
    cs_n = 1'b0;
    oe_bad = 0;
    rd_word = '0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [31:0] word, input int first, input int n, input bit is_read);
    int i;
    logic exp_oe;
    for (int k = 0; k < n; k++) begin
      i = first + k;
      mosi = (i < 32) ? word[31-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      exp_oe = is_read && (i >= 16) && (i < 32);
      if (i >= 16 && i < 32) rd_word = {rd_word[14:0], miso};
      if (miso_oe !== exp_oe) oe_bad++;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({miso, miso_oe, frame_done, frame_err, ram.ram_we, ram.ram_re} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 000000",
                      {miso, miso_oe, frame_done, frame_err, ram.ram_we, ram.ram_re});
    end
    total++;
    if ({ram.ram_write_addr, ram.ram_read_addr, ram.ram_data_in} !== 32'h0) begin
      bad++; $display("FAIL reset_bus: got %h want 0",
                      {ram.ram_write_addr, ram.ram_read_addr, ram.ram_data_in});
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if ({miso_oe, frame_err, ram.ram_we, ram.ram_re} !== 4'b0) begin
      bad++; $display("FAIL post_reset_idle: got %b want 0000", {miso_oe, frame_err, ram.ram_we, ram.ram_re});
    end
  endtask

  task automatic test_write();
    int d0 = n_done, e0 = n_err;
    wr_t e, o;
    wr_exp.push_back(wr_t'{8'h3C, 16'hBEEF, 1'b1});
    spi_start(); spi_bits(32'h803C_BEEF, 0, 32, 1'b0); spi_end();
    total++;
    if (wr_obs.size() !== wr_exp.size()) begin
      bad++; $display("FAIL write_count: got %0d want %0d", wr_obs.size(), wr_exp.size());
    end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      e = wr_exp.pop_front(); o = wr_obs.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL write_data: got %h want %h", o, e); end
    end
    wr_exp.delete(); wr_obs.delete();
    total++;
    if (n_done - d0 !== 1) begin bad++; $display("FAIL write_done: got %0d want 1", n_done - d0); end
    total++;
    if (oe_bad !== 0 || n_err !== e0) begin
      bad++; $display("FAIL write_oe_err: got oe_bad=%0d err=%0d want 0 0", oe_bad, n_err - e0);
    end
  endtask

  task automatic test_read();
    int d0 = n_done;
    logic [7:0] ea, oa;
    re_exp.push_back(8'h3C);
    spi_start(); spi_bits(32'h003C_0000, 0, 32, 1'b1); spi_end();
    total++;
    if (re_obs.size() !== re_exp.size()) begin
      bad++; $display("FAIL read_re_count: got %0d want %0d", re_obs.size(), re_exp.size());
    end
    while (re_exp.size() > 0 && re_obs.size() > 0) begin
      ea = re_exp.pop_front(); oa = re_obs.pop_front();
      total++;
      if (oa !== ea) begin bad++; $display("FAIL read_addr: got %h want %h", oa, ea); end
    end
    re_exp.delete(); re_obs.delete();
    total++;
    if (rd_word !== 16'hBEEF) begin bad++; $display("FAIL read_miso: got %h want beef", rd_word); end
    total++;
    if (oe_bad !== 0) begin bad++; $display("FAIL read_oe: got %0d bad samples want 0", oe_bad); end
    total++;
    if (miso_oe !== 1'b0 || wr_obs.size() !== 0 || n_done - d0 !== 1) begin
      bad++; $display("FAIL read_end: got oe=%b wr=%0d done=%0d want 0 0 1", miso_oe, wr_obs.size(), n_done - d0);
    end
    wr_obs.delete();
  endtask

  task automatic test_abort();
    int d0 = n_done, e0 = n_err;
    wr_t e, o;
    spi_start(); spi_bits(32'h8010_A000, 0, 28, 1'b0); spi_end();
    total++;
    if (n_err - e0 !== 1 || n_done !== d0 || wr_obs.size() !== 0) begin
      bad++; $display("FAIL abort: got err=%0d done=%0d wr=%0d want 1 0 0", n_err - e0, n_done - d0, wr_obs.size());
    end
    wr_obs.delete();
    wr_exp.push_back(wr_t'{8'h11, 16'h1234, 1'b1});
    spi_start(); spi_bits(32'h8011_1234, 0, 32, 1'b0); spi_end();
    total++;
    if (wr_obs.size() !== 1) begin bad++; $display("FAIL abort_retry_count: got %0d want 1", wr_obs.size()); end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      e = wr_exp.pop_front(); o = wr_obs.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL abort_retry_data: got %h want %h", o, e); end
    end
    wr_exp.delete(); wr_obs.delete();
  endtask

  task automatic test_back_to_back();
    int e0 = n_err;
    wr_t e, o;
    wr_exp.push_back(wr_t'{8'hFF, 16'hA5A5, 1'b1});
    spi_start(); spi_bits(32'hFFFF_A5A5, 0, 32, 1'b0); spi_end();
    spi_start(); spi_bits(32'h7FFF_0000, 0, 32, 1'b1); spi_end();
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      e = wr_exp.pop_front(); o = wr_obs.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL b2b_write: got %h want %h", o, e); end
    end
    total++;
    if (wr_exp.size() !== 0 || wr_obs.size() !== 0) begin
      bad++; $display("FAIL b2b_write_count: got left exp=%0d obs=%0d want 0 0", wr_exp.size(), wr_obs.size());
    end
    wr_exp.delete(); wr_obs.delete();
    total++;
    if (rd_word !== 16'hA5A5) begin bad++; $display("FAIL b2b_read: got %h want a5a5", rd_word); end
    total++;
    if (re_obs.size() !== 1 || n_err !== e0) begin
      bad++; $display("FAIL b2b_re_err: got re=%0d err=%0d want 1 0", re_obs.size(), n_err - e0);
    end
    re_obs.delete();
  endtask

  task automatic test_long_frame();
    int d0 = n_done, e0 = n_err;
    wr_t e, o;
    wr_exp.push_back(wr_t'{8'h01, 16'h0F0F, 1'b1});
    spi_start(); spi_bits(32'h8001_0F0F, 0, 40, 1'b0); spi_end();
    total++;
    if (wr_obs.size() !== 1) begin bad++; $display("FAIL long_count: got %0d want 1", wr_obs.size()); end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      e = wr_exp.pop_front(); o = wr_obs.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL long_data: got %h want %h", o, e); end
    end
    wr_exp.delete(); wr_obs.delete();
    total++;
    if (n_done - d0 !== 1 || n_err !== e0) begin
      bad++; $display("FAIL long_done_err: got done=%0d err=%0d want 1 0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0 = n_done, e0 = n_err;
    wr_t e, o;
    spi_start(); spi_bits(32'h8022_7777, 0, 20, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({miso, miso_oe, frame_done, frame_err, ram.ram_we, ram.ram_re, ram.ram_write_addr,
         ram.ram_read_addr, ram.ram_data_in} !== 38'h0) begin
      bad++; $display("FAIL midrst_outputs: got %h want 0", {miso, miso_oe, frame_done, frame_err,
                      ram.ram_we, ram.ram_re, ram.ram_write_addr, ram.ram_read_addr, ram.ram_data_in});
    end
    rst_n = 1'b1;
    spi_bits(32'h8022_7777, 20, 12, 1'b0);
    repeat (2 * HALF) @(negedge clk);
    total++;
    if (wr_obs.size() !== 0 || n_done !== d0 || ram.ram_data_in !== 16'h0) begin
      bad++; $display("FAIL midrst_ignored: got wr=%0d done=%0d din=%h want 0 0 0", wr_obs.size(), n_done - d0, ram.ram_data_in);
    end
    wr_obs.delete();
    spi_end();
    wr_exp.push_back(wr_t'{8'h22, 16'h5555, 1'b1});
    spi_start(); spi_bits(32'h8022_5555, 0, 32, 1'b0); spi_end();
    total++;
    if (wr_obs.size() !== 1 || n_err !== e0) begin
      bad++; $display("FAIL midrst_resume: got wr=%0d err=%0d want 1 0", wr_obs.size(), n_err - e0);
    end
    while (wr_exp.size() > 0 && wr_obs.size() > 0) begin
      e = wr_exp.pop_front(); o = wr_obs.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL midrst_data: got %h want %h", o, e); end
    end
    wr_exp.delete(); wr_obs.delete();
    total++;
    if (n_both !== 0) begin bad++; $display("FAIL we_re_overlap: got %0d want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_back_to_back();
    test_long_frame();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
